// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, instruction-class and encoding constants for alu_ctrl_fsm
package ctrl_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, BRANCH, TRAP} state_t;
    typedef enum logic [2:0] {ADDI, ADD, BEQ, BNE, ILLEGAL} iclass_t;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
endpackage

// File: rtl/alu_ctrl_fsm_sign_extend.sv
// sign_extend: I-type or B-type immediate extraction with sign extension
module sign_extend #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    input  logic                  is_branch,
    output logic [DATA_WIDTH-1:0] imm
);
    logic [12:0] b_imm;
    logic        unused;
    assign b_imm  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm    = is_branch ? {{(DATA_WIDTH-13){b_imm[12]}}, b_imm}
                              : {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign unused = ^{instr[19:12], instr[6:0]};
endmodule

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle sequencer for addi/add/beq/bne; anything else traps
module alu_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic                  eq,
    output logic                  ir_load,
    output logic [2:0]            alu_ctrl,
    output logic                  alu_src,
    output logic [DATA_WIDTH-1:0] imm_op,
    output logic                  reg_write,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  trap,
    output logic [31:0]           retired
);
    state_t                state, next;
    iclass_t               cls, dec;
    logic [31:0]           ir;
    logic [DATA_WIDTH-1:0] ext;
    logic [6:0]            opcode, funct7;
    logic [2:0]            funct3;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always_comb begin
        dec = ILLEGAL;
        if (opcode == OP_IMM && funct3 == F3_ADD) dec = ADDI;
        else if (opcode == OP_REG && funct3 == F3_ADD && funct7 == F7_ADD) dec = ADD;
        else if (opcode == OP_BRANCH && funct3 == F3_BEQ) dec = BEQ;
        else if (opcode == OP_BRANCH && funct3 == F3_BNE) dec = BNE;
    end

    sign_extend #(.DATA_WIDTH(DATA_WIDTH)) u_sext (
        .instr(ir),
        .is_branch(opcode == OP_BRANCH),
        .imm(ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            ir      <= '0;
            cls     <= ILLEGAL;
            imm_op  <= '0;
            retired <= '0;
        end else begin
            state <= next;
            if (state == FETCH) ir <= instr;
            if (state == DECODE) begin
                cls    <= dec;
                imm_op <= (dec == ADD) ? '0 : ext;
            end
            if (state == WRITEBACK || state == BRANCH) retired <= retired + 32'd1;
        end
    end

    // Strobes are gated by rst so an abandoned instruction never commits.
    always_comb begin
        next      = state;
        ir_load   = 1'b0;
        alu_ctrl  = ALU_ADD;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        trap      = 1'b0;
        unique case (state)
            FETCH: begin
                ir_load = !rst;
                next    = DECODE;
            end
            DECODE:
                next = (dec == ILLEGAL) ? TRAP : (dec == BEQ || dec == BNE) ? BRANCH : EXECUTE;
            EXECUTE: begin
                alu_src = (cls == ADDI);
                next    = WRITEBACK;
            end
            WRITEBACK: begin
                alu_src   = (cls == ADDI);
                reg_write = !rst;
                pc_write  = !rst;
                next      = FETCH;
            end
            BRANCH: begin
                alu_ctrl = ALU_SUB;
                pc_write = !rst;
                pc_src   = (cls == BEQ) ? eq : !eq;
                next     = FETCH;
            end
            TRAP:
                trap = 1'b1;
            default:
                next = FETCH;
        endcase
    end
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: directed-vector bench for the alu_ctrl_fsm sequencer
module tb_alu_ctrl_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        eq = 1'b0;
    logic        ir_load, alu_src, reg_write, pc_write, pc_src, trap;
    logic [2:0]  alu_ctrl;
    logic [31:0] imm_op, retired;
    int          tests = 0;
    int          failed = 0;

    alu_ctrl_fsm #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .eq(eq),
        .ir_load(ir_load), .alu_ctrl(alu_ctrl), .alu_src(alu_src), .imm_op(imm_op),
        .reg_write(reg_write), .pc_write(pc_write), .pc_src(pc_src),
        .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (ir_load !== 1'b0) begin failed++; $display("FAIL reset_ir_load got %b want 0", ir_load); end
        tests++; if ({reg_write, pc_write} !== 2'b00) begin failed++; $display("FAIL reset_strobes got %b want 00", {reg_write, pc_write}); end
        tests++; if (trap !== 1'b0) begin failed++; $display("FAIL reset_trap got %b want 0", trap); end
        tests++; if (imm_op !== 32'h0) begin failed++; $display("FAIL reset_imm got %h want 0", imm_op); end
        tests++; if (retired !== 32'h0) begin failed++; $display("FAIL reset_retired got %h want 0", retired); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (ir_load !== 1'b1) begin failed++; $display("FAIL reset_fetch ir_load got %b want 1", ir_load); end
    endtask

    task automatic test_addi(input logic [31:0] r0);
        instr = 32'h00500093;
        #1;
        tests++; if ({ir_load, pc_write, reg_write} !== 3'b100) begin failed++; $display("FAIL addi_fetch got %b want 100", {ir_load, pc_write, reg_write}); end
        @(negedge clk);
        instr = '0;
        eq = 1'b1;
        #1;
        tests++; if ({ir_load, pc_write, reg_write} !== 3'b000) begin failed++; $display("FAIL addi_decode got %b want 000", {ir_load, pc_write, reg_write}); end
        @(negedge clk);
        #1;
        tests++; if ({alu_ctrl, alu_src} !== 4'b0001) begin failed++; $display("FAIL addi_exec_alu got %b want 0001", {alu_ctrl, alu_src}); end
        tests++; if (imm_op !== 32'd5) begin failed++; $display("FAIL addi_exec_imm got %h want 5", imm_op); end
        tests++; if ({reg_write, pc_write, pc_src} !== 3'b000) begin failed++; $display("FAIL addi_exec_strobes got %b want 000", {reg_write, pc_write, pc_src}); end
        @(negedge clk);
        #1;
        tests++; if ({reg_write, pc_write, pc_src, alu_src} !== 4'b1101) begin failed++; $display("FAIL addi_wb got %b want 1101", {reg_write, pc_write, pc_src, alu_src}); end
        eq = 1'b0;
        @(negedge clk);
        #1;
        tests++; if (retired !== r0 + 32'd1) begin failed++; $display("FAIL addi_retired got %h want %h", retired, r0 + 32'd1); end
        tests++; if (ir_load !== 1'b1) begin failed++; $display("FAIL addi_next_fetch got %b want 1", ir_load); end
    endtask

    task automatic test_branch(input logic [31:0] word, input logic eq_v, input logic exp_src, input logic [31:0] r0);
        instr = word;
        #1;
        @(negedge clk);
        instr = '0;
        #1;
        tests++; if ({pc_write, reg_write} !== 2'b00) begin failed++; $display("FAIL br_decode %h got %b want 00", word, {pc_write, reg_write}); end
        @(negedge clk);
        eq = eq_v;
        #1;
        tests++; if (imm_op !== 32'hFFFFFFFC) begin failed++; $display("FAIL br_imm %h got %h want fffffffc", word, imm_op); end
        tests++; if ({alu_ctrl, alu_src} !== 4'b0010) begin failed++; $display("FAIL br_alu %h got %b want 0010", word, {alu_ctrl, alu_src}); end
        tests++; if ({pc_write, pc_src, reg_write} !== {1'b1, exp_src, 1'b0}) begin failed++; $display("FAIL br_pc %h eq=%b got %b want %b", word, eq_v, {pc_write, pc_src, reg_write}, {1'b1, exp_src, 1'b0}); end
        @(negedge clk);
        eq = 1'b0;
        #1;
        tests++; if (retired !== r0 + 32'd1) begin failed++; $display("FAIL br_retired %h got %h want %h", word, retired, r0 + 32'd1); end
    endtask

    task automatic test_add_rst_in_writeback;
        instr = 32'h002081B3;
        #1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if ({alu_ctrl, alu_src} !== 4'b0000) begin failed++; $display("FAIL add_exec_alu got %b want 0000", {alu_ctrl, alu_src}); end
        tests++; if (imm_op !== 32'h0) begin failed++; $display("FAIL add_exec_imm got %h want 0", imm_op); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if ({reg_write, pc_write} !== 2'b00) begin failed++; $display("FAIL add_rst_strobes got %b want 00", {reg_write, pc_write}); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (ir_load !== 1'b1) begin failed++; $display("FAIL add_rst_fetch got %b want 1", ir_load); end
        tests++; if (retired !== 32'h0) begin failed++; $display("FAIL add_rst_retired got %h want 0", retired); end
    endtask

    task automatic test_illegal;
        instr = 32'hFFFFFFFF;
        #1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (trap !== 1'b1) begin failed++; $display("FAIL illegal_trap got %b want 1", trap); end
        for (int i = 0; i < 10; i++) begin
            eq = i[0];
            @(negedge clk);
            #1;
            tests++; if ({trap, pc_write, reg_write, ir_load} !== 4'b1000 || retired !== 32'h0) begin
                failed++; $display("FAIL illegal_hold[%0d] got %b/%h want 1000/0", i, {trap, pc_write, reg_write, ir_load}, retired);
            end
        end
        eq = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if ({trap, ir_load} !== 2'b01) begin failed++; $display("FAIL illegal_rst got %b want 01", {trap, ir_load}); end
    endtask

    task automatic test_retired_wrap;
        force dut.retired = 32'hFFFFFFFF;
        instr = 32'hFE008EE3;
        eq = 1'b0;
        @(negedge clk);
        release dut.retired;
        #1;
        tests++; if (retired !== 32'hFFFFFFFF) begin failed++; $display("FAIL wrap_preload got %h want ffffffff", retired); end
        @(negedge clk);
        #1;
        tests++; if ({pc_write, pc_src} !== 2'b10) begin failed++; $display("FAIL wrap_beq_nottaken got %b want 10", {pc_write, pc_src}); end
        @(negedge clk);
        #1;
        tests++; if (retired !== 32'h0) begin failed++; $display("FAIL wrap_retired got %h want 0", retired); end
    endtask

    initial begin
        test_reset();
        test_addi(32'd0);
        test_branch(32'hFE009EE3, 1'b0, 1'b1, 32'd1);
        test_branch(32'hFE009EE3, 1'b1, 1'b0, 32'd2);
        test_branch(32'hFE008EE3, 1'b1, 1'b1, 32'd3);
        test_branch(32'hFE008EE3, 1'b0, 1'b0, 32'd4);
        test_addi(32'd5);
        test_add_rst_in_writeback();
        test_illegal();
        test_retired_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_ctrl_fsm.md
# alu_ctrl_fsm

Multi-cycle control sequencer that drives the ALU and datapath of the lab RISC-V core: it latches each instruction, decodes it, issues the ALU control code and operand select, and consumes the ALU's `eq` flag to resolve branches. It sits between instruction memory and the register-file/ALU/PC datapath, producing every enable the datapath needs. It supports `addi`, `add`, `beq` and `bne`. Any other encoding traps.

## Interface
- `DATA_WIDTH`, default 32: width of the immediate output.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset; synchronous, active-high.
- `instr` input, 32 bits: instruction word from instruction memory, valid in FETCH.
- `eq` input, 1 bit: ALU equality flag, valid combinationally while `alu_ctrl`/`alu_src` are driven.
- `ir_load` output, 1 bit: instruction register load strobe.
- `alu_ctrl` output, 3 bits: ALU operation; 3'b000 add, 3'b001 sub.
- `alu_src` output, 1 bit: 0 selects `rs2` as ALU operand 2; 1 selects `imm_op`.
- `imm_op` output, DATA_WIDTH bits: sign-extended immediate.
- `reg_write` output, 1 bit: register-file write enable for `rd`.
- `pc_write` output, 1 bit: PC update enable.
- `pc_src` output, 1 bit: 0 selects PC+4; 1 selects PC+`imm_op`.
- `trap` output, 1 bit: sticky illegal-instruction flag.
- `retired` output, 32 bits: count of completed instructions.

## Operation
- States: FETCH, DECODE, EXECUTE, WRITEBACK, BRANCH, TRAP.
- FETCH:
  - `ir_load`=1; `instr` is captured internally.
  - Next state is always DECODE.
- DECODE:
  - Classifies the captured word:
    - opcode 0010011, funct3 000: ADDI.
    - opcode 0110011, funct3 000, funct7 0000000: ADD.
    - opcode 1100011, funct3 000: BEQ.
    - opcode 1100011, funct3 001: BNE.
    - Anything else: illegal.
  - Registers `imm_op`:
    - I-type: sext(instr[31:20]).
    - B-type: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
    - ADD: 0.
  - Next state: ADDI/ADD go to EXECUTE; branches go to BRANCH; illegal goes to TRAP.
- EXECUTE:
  - `alu_ctrl`=000; `alu_src`=1 for ADDI, 0 for ADD.
  - Next state is WRITEBACK.
- WRITEBACK:
  - `alu_ctrl`/`alu_src` held from EXECUTE.
  - `reg_write`=1, `pc_write`=1, `pc_src`=0.
  - `retired` increments; next state is FETCH.
- BRANCH:
  - `alu_ctrl`=001, `alu_src`=0.
  - Taken = `eq` for BEQ, !`eq` for BNE.
  - `pc_write`=1, `pc_src`=taken.
  - `retired` increments; next state is FETCH.
- TRAP:
  - `trap`=1; all enables stay 0.
  - Remains in TRAP until `rst`.
- Outputs not listed for a state are 0. `imm_op` holds its value until the next DECODE.
- `retired` is modulo 2^32 and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - `rst` is sampled on the rising `clk` edge; the next state is FETCH.
  - `imm_op`=0, `retired`=0, `trap`=0.
  - All strobes are 0 during the reset cycle.
- `rst` asserted in any state, including mid-instruction: the current cycle's `reg_write`/`pc_write` are forced to 0 and the in-flight instruction is abandoned without incrementing `retired`.
- Latency:
  - ADDI/ADD take 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Branches take 3 cycles (FETCH, DECODE, BRANCH).
- Exactly one `pc_write` pulse per retired instruction; `reg_write` never asserts with `pc_src`=1.
- `eq` is sampled only in BRANCH; it is ignored in all other states.
- All outputs are Moore-style from state and registered decode fields, except `pc_src` in BRANCH, which depends combinationally on `eq`.

## Structure
- Package `ctrl_pkg` holds:
  - The state enum.
  - Opcode/funct3/funct7 localparams.
  - ALU control codes ALU_ADD=3'b000 and ALU_SUB=3'b001.
  - The instruction-class enum {ADDI, ADD, BEQ, BNE, ILLEGAL}.
- Sub-module `sign_extend`:
  - Combinational.
  - Inputs: instruction word and an `is_branch` select.
  - Output: DATA_WIDTH-bit immediate.

## Test plan
- `addi x1,x0,5` (0x00500093):
  - `ir_load` in cycle 0.
  - Cycle 2: `alu_ctrl`=000, `alu_src`=1, `imm_op`=5.
  - Cycle 3: `reg_write`=`pc_write`=1, `pc_src`=0.
  - `retired`=1.
- `bne x1,x0,-4` (0xFE009EE3) with `eq`=0 in BRANCH: `imm_op`=0xFFFFFFFC, `alu_ctrl`=001, `pc_write`=1, `pc_src`=1, `reg_write`=0.
- Same word with `eq`=1: `pc_src`=0, `pc_write`=1; `beq` with `eq`=1 gives `pc_src`=1.
- Illegal word 0xFFFFFFFF: TRAP after DECODE, `trap`=1 held for 10 further cycles, no `pc_write`/`reg_write`, `retired` unchanged; `rst` clears `trap`.
- `rst` pulsed in the WRITEBACK cycle of `add x3,x1,x2` (0x002081B3): `reg_write`=`pc_write`=0 that cycle, FETCH next, `retired`=0.
- Preload `retired` to 0xFFFFFFFF via 2^32-1 retirements (or a force) and retire one more instruction: `retired`=0.
